// File: rtl/sram_dump_if.sv
// Bundles the SRAM read port and the (address, data) output stream of sram_dump_unit.
// master = dump unit side, slave = SRAM / sink side.
interface sram_dump_if #(
    parameter int word_size = 8,
    parameter int addr_size = 8
) ();
    logic                 mem_rd;
    logic [addr_size-1:0] mem_addr;
    logic [word_size-1:0] mem_data;

    // Stream: a beat transfers on every rising edge where out_valid && out_ready.
    // Once out_valid is high, out_addr/out_data/out_last hold until that edge.
    logic                 out_valid;
    logic                 out_ready;
    logic [addr_size-1:0] out_addr;
    logic [word_size-1:0] out_data;
    logic                 out_last;

    modport master (
        output mem_rd, mem_addr,
        input  mem_data,
        output out_valid, out_addr, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_data,
        input  out_valid, out_addr, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/sram_dump_unit.sv
// Walks an inclusive, wrapping SRAM address range and streams (address, data) beats.
// Optional macro DUMP_CHECKSUM_EN adds a running modulo checksum output csum.
module sram_dump_unit #(
    parameter int word_size = 8,
    parameter int addr_size = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [addr_size-1:0] start_addr,
    input  logic [addr_size-1:0] end_addr,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           dbg_state,
`ifdef DUMP_CHECKSUM_EN
    output logic [word_size-1:0] csum,
`endif
    sram_dump_if.master          bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0]         LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [addr_size:0] REM_ONE  = (addr_size+1)'(1);
    localparam logic [addr_size-1:0] ADDR_ONE = addr_size'(1);

    state_t state_q, state_d;

    logic [addr_size-1:0] cur_q, cur_d;
    // One bit wider than the address so a full-memory dump count fits.
    logic [addr_size:0]   rem_q, rem_d;
    logic [1:0]           wait_q, wait_d;
    logic [addr_size-1:0] out_addr_q, out_addr_d;
    logic [word_size-1:0] out_data_q, out_data_d;
    logic                 last_q, last_d;
`ifdef DUMP_CHECKSUM_EN
    logic [word_size-1:0] csum_q, csum_d;
`endif

    logic handshake;
    assign handshake = (state_q == S_SEND) && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_READ;
            S_READ: state_d = S_WAIT;
            S_WAIT: if (wait_q == LAT_LAST) state_d = S_SEND;
            S_SEND: if (bus.out_ready) state_d = last_q ? S_DONE : S_READ;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_rd    = (state_q == S_READ);
        bus.mem_addr  = (state_q == S_READ) ? cur_q : '0;
        bus.out_valid = (state_q == S_SEND);
        bus.out_last  = (state_q == S_SEND) && last_q;
        bus.out_addr  = out_addr_q;
        bus.out_data  = out_data_q;
        busy          = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_SEND);
        done          = (state_q == S_DONE);
        dbg_state     = state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q      <= '0;
            rem_q      <= '0;
            wait_q     <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            last_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            cur_q      <= cur_d;
            rem_q      <= rem_d;
            wait_q     <= wait_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            last_q     <= last_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        cur_d      = cur_q;
        rem_d      = rem_q;
        wait_d     = wait_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        last_d     = last_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_d = start_addr;
                    // Modulo subtraction makes end < start a wrapping range.
                    rem_d = {1'b0, end_addr - start_addr} + REM_ONE;
`ifdef DUMP_CHECKSUM_EN
                    csum_d = '0;
`endif
                end
            end
            S_READ: wait_d = '0;
            S_WAIT: begin
                if (wait_q == LAT_LAST) begin
                    out_addr_d = cur_q;
                    out_data_d = bus.mem_data;
                    last_d     = (rem_q == REM_ONE);
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_SEND: begin
                if (handshake) begin
                    rem_d = rem_q - REM_ONE;
                    cur_d = cur_q + ADDR_ONE;
`ifdef DUMP_CHECKSUM_EN
                    csum_d = csum_q + out_data_q;
`endif
                end
            end
            default: ;
        endcase
    end

`ifdef DUMP_CHECKSUM_EN
    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_sram_dump_unit.sv
// Randomized scoreboard bench for sram_dump_unit: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat and checks hold stability.
module tb_sram_dump_unit;
  localparam int WS     = 8;
  localparam int AS     = 8;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [AS-1:0] start_addr = '0;
  logic [AS-1:0] end_addr = '0;
  logic busy, done;
  logic [2:0] dbg_state;
`ifdef DUMP_CHECKSUM_EN
  logic [WS-1:0] csum;
`endif

  sram_dump_if #(.word_size(WS), .addr_size(AS)) bus ();

  sram_dump_unit #(.word_size(WS), .addr_size(AS), .RD_LAT(RD_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_addr(start_addr),
    .end_addr(end_addr),
    .busy(busy),
    .done(done),
    .dbg_state(dbg_state),
`ifdef DUMP_CHECKSUM_EN
    .csum(csum),
`endif
    .bus(bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  logic [AS+WS:0] exp_q[$];
  logic [WS-1:0] mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM model: data RD_LAT cycles after mem_rd, junk otherwise ----------------
  logic [WS-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    for (int k = RD_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    rd_pipe[0] <= bus.mem_rd ? mem[bus.mem_addr] : WS'($urandom);
  end
  assign bus.mem_data = rd_pipe[RD_LAT-1];

  // ---------------- sink ready driver ----------------
  initial begin
    int cyc;
    cyc = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ((cyc / 3) % 2) == 0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic           have_hold = 1'b0;
  logic [AS+WS:0] held;
  always @(negedge clk) begin
    logic [AS+WS:0] beat;
    logic [AS+WS:0] e;
    if (!rst) begin
      have_hold = 1'b0;
    end else begin
      beat = {bus.out_last, bus.out_addr, bus.out_data};
      if (have_hold) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_beat", 32'(beat), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(beat), 32'h1ffff);
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'(beat), 32'(e));
        end
        have_hold = 1'b0;
      end else if (bus.out_valid) begin
        have_hold = 1'b1;
        held = beat;
      end else begin
        have_hold = 1'b0;
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- reference model: push expected beats of a range ----------------
  task automatic push_range(input int s, input int e, output int sum);
    int n;
    int a;
    n = ((e - s) & 255) + 1;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      a = (s + i) % 256;
      exp_q.push_back({(i == n - 1), AS'(a), mem[a]});
      sum = (sum + mem[a]) % 256;
    end
  endtask

  task automatic pulse_start(input int s, input int e);
    @(negedge clk);
    start = 1'b1;
    start_addr = AS'(s);
    end_addr = AS'(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_dump(input int s, input int e, input int mode, input bit chk_lat, input bit intrude);
    int sum;
    int cyc;
    int guard;
    int d0;
    ready_mode = mode;
    push_range(s, e, sum);
    d0 = done_cnt;
    pulse_start(s, e);
    check("busy_after_start", 32'(busy), 32'd1);
    cyc = 1;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (chk_lat) check("first_valid_latency", cyc, RD_LAT + 2);
    else check("first_valid_seen", 32'(bus.out_valid), 32'd1);
    if (intrude) begin
      pulse_start((s + 77) % 256, (s + 90) % 256);
      check("busy_after_ignored_start", 32'(busy), 32'd1);
    end
    guard = 0;
    while (!done && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("done_reached", 32'(done), 32'd1);
    check("all_beats_before_done", exp_q.size(), 0);
    check("busy_low_at_done", 32'(busy), 32'd0);
`ifdef DUMP_CHECKSUM_EN
    check("csum_at_done", 32'(csum), 32'(sum));
`endif
    if (intrude) begin
      // start coincident with done must be ignored
      start = 1'b1;
      start_addr = AS'(s + 3);
      end_addr = AS'(s + 9);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("start_in_done_ignored", 32'(busy), 32'd0);
    end else begin
      @(posedge clk);
      #1;
    end
    check("done_one_cycle", 32'(done), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("done_pulse_count", done_cnt - d0, 1);
    check("idle_after_dump", 32'(busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 32'({bus.mem_rd, bus.mem_addr, bus.out_valid, bus.out_addr,
                     bus.out_data, bus.out_last, busy, done}), 32'd0);
`ifdef DUMP_CHECKSUM_EN
    check({name, "_csum"}, 32'(csum), 32'd0);
`endif
  endtask

  task automatic reset_mid_dump();
    int sum;
    int sends;
    int guard;
    int d0;
    logic prev;
    ready_mode = 0;
    push_range(0, 14, sum);
    pulse_start(0, 14);
    sends = 0;
    guard = 0;
    prev = 1'b0;
    while (sends < 3 && guard < 200) begin
      if (bus.out_valid && !prev) sends++;
      prev = bus.out_valid;
      if (sends < 3) begin
        @(posedge clk);
        #1;
      end
      guard++;
    end
    check("third_send_reached", sends, 3);
    #1 rst = 1'b0;
    #1;
    check_outputs_zero("outputs_zero_mid_reset");
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt - d0, 0);
    check("idle_after_abort", 32'({busy, bus.out_valid}), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WS-1:0] prog [15];
    int s;
    int e;
    prog = '{8'h00, 8'h50, 8'd130, 8'h51, 8'd131, 8'h52, 8'd128, 8'h53,
             8'd129, 8'h9B, 8'h93, 8'h91, 8'h80, 8'd134, 8'h00};
    for (int i = 0; i < 256; i++) mem[i] = WS'($urandom);
    for (int i = 0; i < 15; i++) mem[i] = prog[i];
    mem[128] = 8'd6;
    mem[129] = 8'd1;
    mem[130] = 8'd2;
    mem[131] = 8'd2;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_outputs");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_dump(0, 14, 0, 1'b1, 1'b0);
    run_dump(128, 131, 1, 1'b0, 1'b0);
    mem[254] = 8'hAA;
    mem[255] = 8'hBB;
    run_dump(254, 1, 2, 1'b0, 1'b0);
    mem[139] = 8'hF0;
    run_dump(139, 139, 0, 1'b1, 1'b0);
    run_dump(0, 255, 0, 1'b0, 1'b0);
    run_dump(20, 30, 2, 1'b0, 1'b1);
    reset_mid_dump();
    run_dump(5, 9, 1, 1'b1, 1'b0);
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = WS'($urandom);
      s = $urandom_range(0, 255);
      e = (s + $urandom_range(0, 40)) % 256;
      run_dump(s, e, $urandom_range(0, 2), 1'b0, 1'b0);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sram_dump_unit.md
Name: sram_dump_unit

Overview:
- Memory readout engine for the RISC_SPM system; the read-side counterpart to the program and data load path that fills the SRAM.
- After the CPU halts, it walks a programmed address range of the SRAM and streams each (address, data) pair out over a valid/ready interface to a bench monitor or debug port.
- Sits beside the SRAM and shares its read port through a simple request/strobe interface.

Parameters:
- word_size, 8, data width of one SRAM word
- addr_size, 8, SRAM address width (memory depth 2**addr_size)
- RD_LAT, 1, SRAM read latency in cycles from mem_rd to valid mem_data (1 or 2 supported)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begin dump (ignored unless idle)
- start_addr  input  addr_size  first address, sampled on accepted start
- end_addr  input  addr_size  last address (inclusive), sampled on accepted start
- mem_rd  output  1  SRAM read strobe, one cycle per word
- mem_addr  output  addr_size  SRAM read address
- mem_data  input  word_size  SRAM read data, valid RD_LAT cycles after mem_rd
- out_valid  output  1  output beat valid
- out_ready  input  1  sink accepts beat when out_valid && out_ready
- out_addr  output  addr_size  address of current beat
- out_data  output  word_size  data of current beat
- out_last  output  1  current beat is end_addr
- busy  output  1  dump in progress
- done  output  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; mem_rd, out_valid, out_last, busy, done=0; mem_addr, out_addr, out_data=0; counters cleared. The same applies when reset is asserted mid-dump: the dump is abandoned with no further beats and no done pulse.
- FSM states: IDLE, READ, WAIT, SEND, DONE.
- IDLE: on start=1, latch cur=start_addr and remaining = ((end_addr - start_addr) mod 2**addr_size) + 1. remaining is addr_size+1 bits wide so a full 256-word dump is representable. busy goes 1 the next cycle -> READ.
- READ: mem_rd=1 and mem_addr=cur for exactly one cycle -> WAIT.
- WAIT: count RD_LAT-1 further cycles, then capture mem_data into out_data and cur into out_addr. Set out_valid=1 and out_last=(remaining==1) -> SEND.
- SEND: hold out_valid, out_addr, out_data and out_last stable until out_ready=1.
  - On handshake: decrement remaining and set cur=cur+1, wrapping 255->0.
  - If it was the last beat -> DONE; else -> READ.
  - out_valid drops on the cycle after the handshake.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- Latency: first out_valid rises RD_LAT+2 cycles after the start pulse. With out_ready tied high, each word costs RD_LAT+2 cycles.
- Wrap-around: end_addr<start_addr dumps start..255 then 0..end_addr. start_addr==end_addr dumps exactly one word with out_last=1.
- start while busy: ignored; start_addr and end_addr are not re-sampled.
- start in the same cycle as done: ignored, because the FSM is still in DONE. A new dump requires a start pulse while in IDLE.
- mem_rd is never asserted outside READ. The unit issues no SRAM writes.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - Adds output port csum[word_size-1:0], an 8-bit modulo-2**word_size running sum of all out_data beats accepted in the current dump.
  - csum is cleared on accepted start and updated on each handshake.
  - csum is stable and valid while done=1, and holds until the next accepted start. Reset clears it to 0.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-dump: start 0..14, assert rst low during the third SEND -> all outputs 0 immediately; after release no beats and no done until a new start.
- Program dump: preload memory[0..14] with the compare/branch test program (0x00,0x50,130,0x51,131,0x52,128,0x53,129,0x9B,0x93,0x91,0x80,134,0), out_ready=1, dump 0..14 -> 15 beats with out_addr 0..14 matching data, out_last only at 14, one done pulse, first out_valid 3 cycles after start (RD_LAT=1).
- Backpressure: dump 128..131 holding 6,1,2,2, with out_ready toggling every 3 cycles -> each beat held stable until accepted, no duplicate or dropped beats; with DUMP_CHECKSUM_EN, csum=11 at done.
- Wrap: memory[254]=0xAA, [255]=0xBB, [0]=0x00, [1]=0x50, dump 254..1 -> beats (254,AA),(255,BB),(0,00),(1,50), out_last on addr 1.
- Single word and full range: dump 139..139 with memory[139]=0xF0 -> exactly one beat (139,F0) with out_last=1. Dump 0..255 -> exactly 256 beats, done once.
- start while busy: pulse start with different start_addr and end_addr during a dump -> original range completes unchanged and no second dump begins.
